// File: rtl/seq_divider_if.sv
//------------------------------------------------------------------------------
// Module   : seq_divider_if
// Purpose  : Handshake/data bundle between an issuing stage (master) and the
//            sequential signed divider (slave).
// Signals  : start, dividend[2W], divisor[W]              master -> slave
//            busy, done, quotient[W], remainder[W],
//            div_by_zero, overflow                        slave  -> master
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface seq_divider_if #(
  parameter int W = 16
);
  logic             start;
  logic [2*W-1:0]   dividend;
  logic [W-1:0]     divisor;
  logic             busy;
  logic             done;
  logic [W-1:0]     quotient;
  logic [W-1:0]     remainder;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero, overflow
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero, overflow
  );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
//------------------------------------------------------------------------------
// Module   : seq_divider
// Purpose  : Multi-cycle signed divider, 2W-bit dividend by W-bit divisor.
//            Restoring division on magnitudes, one quotient bit per clock,
//            signs applied at the end. Quotient truncates toward zero, the
//            remainder takes the dividend's sign.
// Ports    : clk          clock, rising edge
//            rst_n        asynchronous active-low reset
//            bus (slave)  start/dividend/divisor in; busy/done/quotient/
//                         remainder/div_by_zero/overflow out
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module seq_divider #(
  parameter int W = 16
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  seq_divider_if.slave  bus
);

  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [W-1:0]    prem_q,  prem_d;    // partial remainder
  logic [W-1:0]    shreg_q, shreg_d;   // dividend low half in, quotient bits out
  logic [W-1:0]    dvs_q,   dvs_d;     // |divisor|
  logic            sgnq_q,  sgnq_d;
  logic            sgnr_q,  sgnr_d;
  logic            done_q,  done_d;
  logic [W-1:0]    quot_q,  quot_d;
  logic [W-1:0]    rem_q,   rem_d;
  logic            dvz_q,   dvz_d;
  logic            ovf_q,   ovf_d;

  logic [2*W-1:0]  w_dvd_abs;
  logic [W-1:0]    w_dvs_abs;
  logic [W:0]      w_trial;
  logic            w_ge;
  logic [W-1:0]    w_diff;
  logic            w_fix_ovf;

  // Negating the most negative value wraps to itself, which read as unsigned
  // is exactly the correct magnitude.
  assign w_dvd_abs = bus.dividend[2*W-1] ? -bus.dividend : bus.dividend;
  assign w_dvs_abs = bus.divisor[W-1]    ? -bus.divisor  : bus.divisor;

  assign w_trial = {prem_q, shreg_q[W-1]};
  assign w_ge    = (w_trial >= {1'b0, dvs_q});
  // prem_q < dvs_q always holds, so the true difference fits in W bits.
  assign w_diff  = w_trial[W-1:0] - dvs_q;

  // Negative results may reach 2^(W-1); positive ones only 2^(W-1)-1.
  assign w_fix_ovf = sgnq_q ? (shreg_q[W-1] && (|shreg_q[W-2:0])) : shreg_q[W-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= '0;
      prem_q  <= '0;
      shreg_q <= '0;
      dvs_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dvz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      prem_q  <= prem_d;
      shreg_q <= shreg_d;
      dvs_q   <= dvs_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      done_q  <= done_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dvz_q   <= dvz_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    prem_d  = prem_q;
    shreg_d = shreg_q;
    dvs_d   = dvs_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    done_d  = 1'b0;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvz_d   = dvz_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          sgnq_d = bus.dividend[2*W-1] ^ bus.divisor[W-1];
          sgnr_d = bus.dividend[2*W-1];
          if (bus.divisor == '0) begin
            done_d = 1'b1;
            dvz_d  = 1'b1;
            ovf_d  = 1'b0;
            quot_d = '0;
            rem_d  = '0;
          end else if (w_dvd_abs[2*W-1:W] >= w_dvs_abs) begin
            // Quotient magnitude would need more than W bits.
            done_d = 1'b1;
            dvz_d  = 1'b0;
            ovf_d  = 1'b1;
            quot_d = '0;
            rem_d  = '0;
          end else begin
            state_d = S_CALC;
            count_d = '0;
            prem_d  = w_dvd_abs[2*W-1:W];
            shreg_d = w_dvd_abs[W-1:0];
            dvs_d   = w_dvs_abs;
          end
        end
      end

      S_CALC: begin
        prem_d  = w_ge ? w_diff : w_trial[W-1:0];
        shreg_d = {shreg_q[W-2:0], w_ge};
        count_d = count_q + CW'(1);
        if (count_q == CW'(W-1)) begin
          state_d = S_FIX;
        end
      end

      S_FIX: begin
        done_d  = 1'b1;
        dvz_d   = 1'b0;
        state_d = S_IDLE;
        if (w_fix_ovf) begin
          ovf_d  = 1'b1;
          quot_d = '0;
          rem_d  = '0;
        end else begin
          ovf_d  = 1'b0;
          quot_d = sgnq_q ? -shreg_q : shreg_q;
          rem_d  = sgnr_q ? -prem_q  : prem_q;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dvz_q;
  assign bus.overflow    = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_seq_divider.sv
//------------------------------------------------------------------------------
// Module   : tb_seq_divider
// Purpose  : Scoreboard bench for seq_divider. Driver pushes expected results
//            on issue; monitor pops and compares on every done, and checks
//            that outputs hold between completions.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_seq_divider;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dvz;
    logic         ovf;
    int           issue;
    int           lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  exp_t hold = '{q: '0, r: '0, dvz: 1'b0, ovf: 1'b0, issue: 0, lat: 0};

  seq_divider_if #(.W(W)) bus ();

  seq_divider #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: compare on done, otherwise verify the last result is held.
  always @(negedge clk) begin
    if (!rst_n) begin
      hold = '{q: '0, r: '0, dvz: 1'b0, ovf: 1'b0, issue: 0, lat: 0};
    end else if (bus.done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("quotient",    32'(bus.quotient),    32'(e.q));
        chk("remainder",   32'(bus.remainder),   32'(e.r));
        chk("div_by_zero", 32'(bus.div_by_zero), 32'(e.dvz));
        chk("overflow",    32'(bus.overflow),    32'(e.ovf));
        chk("latency",     32'(cyc - e.issue),   32'(e.lat));
        hold = e;
      end
    end else begin
      chk("hold_q",   32'(bus.quotient),    32'(hold.q));
      chk("hold_r",   32'(bus.remainder),   32'(hold.r));
      chk("hold_dvz", 32'(bus.div_by_zero), 32'(hold.dvz));
      chk("hold_ovf", 32'(bus.overflow),    32'(hold.ovf));
    end
  end

  // Expected result for an operation whose start is sampled at the next posedge.
  task automatic push_exp(input logic [W-1:0] q, input logic [W-1:0] r,
                          input logic dvz, input logic ovf, input int lat);
    exp_t e;
    e.q = q; e.r = r; e.dvz = dvz; e.ovf = ovf;
    e.issue = cyc + 1;
    e.lat = lat;
    sb.push_back(e);
  endtask

  // Called at the first negedge after the start edge; returns at the done negedge.
  task automatic wait_done(input int exp_busy);
    int nb = 0;
    int t  = 0;
    while (!bus.done && t < 60) begin
      if (bus.busy) nb++;
      @(negedge clk);
      t++;
    end
    chk("done_timeout", 32'(bus.done), 32'd1);
    chk("busy_cycles",  32'(nb),       32'(exp_busy));
  endtask

  task automatic do_op(input logic [2*W-1:0] dvd, input logic [W-1:0] dvs,
                       input logic [W-1:0] q, input logic [W-1:0] r,
                       input logic dvz, input logic ovf, input int lat);
    push_exp(q, r, dvz, ovf, lat);
    bus.start = 1'b1; bus.dividend = dvd; bus.divisor = dvs;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(lat);
    @(negedge clk);
  endtask

  initial begin
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_q",    32'(bus.quotient), 32'd0);
    chk("rst_r",    32'(bus.remainder), 32'd0);
    #2 rst_n = 1'b1;
    @(negedge clk);

    // Basic and sign combinations
    do_op(32'd100,        16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 17);
    do_op(32'hFFFF_FF9C,  16'd7,      16'hFFF2,   16'hFFFE,   1'b0, 1'b0, 17);
    do_op(32'd100,        16'hFFF9,   16'hFFF2,   16'd2,      1'b0, 1'b0, 17);
    do_op(32'hFFFF_FF9C,  16'hFFF9,   16'd14,     16'hFFFE,   1'b0, 1'b0, 17);
    // Divide by zero and overflow boundaries
    do_op(32'd1234,       16'd0,      16'd0,      16'd0,      1'b1, 1'b0, 0);
    do_op(32'h4000_0000,  16'd2,      16'd0,      16'd0,      1'b0, 1'b1, 0);
    do_op(32'd32768,      16'd1,      16'd0,      16'd0,      1'b0, 1'b1, 17);
    do_op(32'hFFFF_8000,  16'd1,      16'h8000,   16'd0,      1'b0, 1'b0, 17);
    do_op(32'h8000_0000,  16'hFFFF,   16'd0,      16'd0,      1'b0, 1'b1, 0);
    do_op(32'h7FFE_FFFF,  16'h7FFF,   16'd0,      16'd0,      1'b0, 1'b1, 17);
    // Small dividends, remainder sign, zero remainder
    do_op(32'd7,          16'd100,    16'd0,      16'd7,      1'b0, 1'b0, 17);
    do_op(32'hFFFF_FFF9,  16'd100,    16'd0,      16'hFFF9,   1'b0, 1'b0, 17);
    do_op(32'hFFFF_FF9C,  16'd5,      16'hFFEC,   16'd0,      1'b0, 1'b0, 17);

    // start pulsed during CALC is ignored
    push_exp(16'd14, 16'd2, 1'b0, 1'b0, 17);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.dividend = 32'd5; bus.divisor = 16'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(12);
    @(negedge clk);

    // start held through done: back-to-back, prior result held meanwhile
    push_exp(16'd14, 16'd2, 1'b0, 1'b0, 17);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd7;
    @(negedge clk);
    wait_done(17);
    push_exp(16'd30, 16'd10, 1'b0, 1'b0, 17);
    bus.dividend = 32'd1000; bus.divisor = 16'd33;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(17);
    @(negedge clk);

    // Reset in the middle of an operation
    push_exp(16'd14, 16'd2, 1'b0, 1'b0, 17);
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 16'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(bus.busy),        32'd0);
    chk("midrst_done", 32'(bus.done),        32'd0);
    chk("midrst_q",    32'(bus.quotient),    32'd0);
    chk("midrst_r",    32'(bus.remainder),   32'd0);
    chk("midrst_dvz",  32'(bus.div_by_zero), 32'd0);
    chk("midrst_ovf",  32'(bus.overflow),    32'd0);
    sb.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    do_op(32'd100,        16'd7,      16'd14,     16'd2,      1'b0, 1'b0, 17);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
